// File: rtl/m_pkg.sv
// Shared types for the streaming match engine: word formats, match-entry layout,
// FSM states and the length-to-byte-mask helper.
package m_pkg;
  localparam logic [7:0] WCNT_MAX = 8'hFF;

  typedef logic [7:0] byte_mask_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  length;
    logic [63:0] data;
  } in_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  length;
    logic [63:0] data;
    logic [7:0]  buffer;
  } out_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  off;
    logic [63:0] match;
    logic [7:0]  buffer;
  } sym_match_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  off;
    logic [63:0] match;
    byte_mask_t  mask;
    logic [7:0]  buffer;
  } sym_match_mask_t;

  typedef enum logic {IDLE, IN_PKT} match_state_t;

  // length is byte count minus 1, so bits 0..length are set
  function automatic byte_mask_t len_to_unary_mask(input logic [2:0] length);
    byte_mask_t m;
    m = '0;
    for (int b = 0; b < 8; b++)
      if (b <= int'(length)) m[b] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/m_match_cmp.sv
// One match entry against the current word: offset equality plus masked byte
// compare, with bytes past the eop length never counted as matching.
module m_match_cmp
  import m_pkg::*;
(
  input  sym_match_mask_t entry,
  input  logic [7:0]      wcnt,
  input  logic [63:0]     data,
  input  logic            eop,
  input  logic [2:0]      length,
  output logic            hit
);
  byte_mask_t vmask;
  byte_mask_t byte_ok;

  always_comb begin
    vmask = eop ? len_to_unary_mask(length) : 8'hFF;
    for (int b = 0; b < 8; b++)
      byte_ok[b] = !entry.mask[b] ||
                   (vmask[b] && (data[8*b +: 8] == entry.match[8*b +: 8]));
    hit = entry.valid && (entry.off == wcnt) && (&byte_ok);
  end
endmodule

// File: rtl/m_match_engine.sv
// Streaming classifier: tags each packet word with a sticky buffer token from the
// lowest-index matching entry; shadow table is committed to active at each sop.
module m_match_engine
  import m_pkg::*;
#(
  parameter int         N_MATCH        = 4,
  parameter logic [7:0] DEFAULT_BUFFER = 8'h00,
  localparam int        IDX_W          = (N_MATCH > 1) ? $clog2(N_MATCH) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_vld,
  input  logic [$bits(in_t)-1:0]              in,
  output logic                                in_rdy,
  output logic                                out_vld,
  output logic [$bits(out_t)-1:0]             out,
  input  logic                                out_rdy,
  input  logic                                cfg_vld,
  input  logic [IDX_W-1:0]                    cfg_idx,
  input  logic [$bits(sym_match_mask_t)-1:0]  cfg_entry,
  output logic [15:0]                         drop_cnt
);
  in_t             w;
  match_state_t    state, state_nxt;
  sym_match_mask_t shadow [N_MATCH];
  sym_match_mask_t active [N_MATCH];
  sym_match_mask_t tab    [N_MATCH];
  logic [N_MATCH-1:0] hit;
  logic [7:0]      wcnt, wcnt_cur, verdict_buf, cur_buf;
  logic            verdict_hit, cur_hit, accept, emit, bump;

  assign w        = in;
  assign in_rdy   = !out_vld || out_rdy;
  assign accept   = in_vld && in_rdy;
  assign wcnt_cur = w.sop ? 8'd0 : wcnt;

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    bump      = 1'b0;
    if (accept) begin
      if (w.sop) begin
        emit      = 1'b1;
        bump      = (state == IN_PKT);
        state_nxt = w.eop ? IDLE : IN_PKT;
      end else if (state == IDLE) begin
        bump = 1'b1;
      end else begin
        emit = 1'b1;
        if (w.eop) state_nxt = IDLE;
      end
    end
  end

  // A sop word is classified with the table it is about to commit
  always_comb
    for (int i = 0; i < N_MATCH; i++) tab[i] = w.sop ? shadow[i] : active[i];

  for (genvar i = 0; i < N_MATCH; i++) begin : g_cmp
    m_match_cmp u_cmp (
      .entry  (tab[i]),
      .wcnt   (wcnt_cur),
      .data   (w.data),
      .eop    (w.eop),
      .length (w.length),
      .hit    (hit[i])
    );
  end

  always_comb begin
    cur_hit = verdict_hit && !w.sop;
    cur_buf = verdict_buf;
    if (!cur_hit)
      for (int i = N_MATCH - 1; i >= 0; i--)
        if (hit[i]) begin
          cur_hit = 1'b1;
          cur_buf = tab[i].buffer;
        end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      verdict_hit <= 1'b0;
      verdict_buf <= '0;
      out_vld     <= 1'b0;
      out         <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < N_MATCH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (bump && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (emit) begin
        wcnt        <= (wcnt_cur == WCNT_MAX) ? WCNT_MAX : wcnt_cur + 8'd1;
        verdict_hit <= cur_hit;
        verdict_buf <= cur_buf;
        out_vld     <= 1'b1;
        out         <= {w.sop, w.eop, w.length, w.data,
                        cur_hit ? cur_buf : DEFAULT_BUFFER};
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
      if (emit && w.sop)
        for (int i = 0; i < N_MATCH; i++) active[i] <= shadow[i];
      if (cfg_vld && int'(cfg_idx) < N_MATCH) shadow[cfg_idx] <= cfg_entry;
    end
  end
endmodule

// File: tb/tb_m_match_engine.sv
// Scoreboard bench for m_match_engine: directed scenarios plus random traffic,
// checked against a packet-level reference model.
module tb_m_match_engine;
  import m_pkg::*;
  localparam int         N   = 4;
  localparam logic [7:0] DEF = 8'h00;

  logic clk = 0, rst = 1, in_vld = 0, out_rdy = 0, cfg_vld = 0;
  logic in_rdy, out_vld;
  in_t  in_w = '0;
  logic [$bits(out_t)-1:0] out_raw;
  logic [1:0] cfg_idx = '0;
  sym_match_mask_t cfg_e = '0;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  m_match_engine #(.N_MATCH(N), .DEFAULT_BUFFER(DEF)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in(in_w), .in_rdy(in_rdy),
    .out_vld(out_vld), .out(out_raw), .out_rdy(out_rdy),
    .cfg_vld(cfg_vld), .cfg_idx(cfg_idx), .cfg_entry(cfg_e), .drop_cnt(drop_cnt)
  );

  // reference model state
  sym_match_mask_t sh [N];
  sym_match_mask_t ac [N];
  bit   in_pkt;
  int   wc, verdict, m_drop;
  out_t expq [$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit bytes_ok(sym_match_mask_t e, in_t x);
    for (int b = 0; b < 8; b++)
      if (e.mask[b]) begin
        if (x.eop && b > int'(x.length)) return 0;
        if (x.data[8*b +: 8] != e.match[8*b +: 8]) return 0;
      end
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin sh[i] = '0; ac[i] = '0; end
    in_pkt = 0; wc = 0; verdict = -1; m_drop = 0;
    expq.delete();
  endtask

  task automatic model_word(in_t x);
    out_t o;
    if (!x.sop && !in_pkt) begin
      if (m_drop < 65535) m_drop++;
      return;
    end
    if (x.sop) begin
      if (in_pkt && m_drop < 65535) m_drop++;
      ac = sh; wc = 0; verdict = -1;
    end
    for (int i = 0; i < N; i++)
      if (verdict < 0 && ac[i].valid && int'(ac[i].off) == wc && bytes_ok(ac[i], x))
        verdict = int'(ac[i].buffer);
    o.sop = x.sop; o.eop = x.eop; o.length = x.length; o.data = x.data;
    o.buffer = (verdict < 0) ? DEF : verdict[7:0];
    expq.push_back(o);
    in_pkt = !x.eop;
    if (wc < 255) wc++;
  endtask

  function automatic in_t mk(bit s, bit e, int len, logic [63:0] d);
    in_t x;
    x.sop = s; x.eop = e; x.length = len[2:0]; x.data = d;
    return x;
  endfunction

  function automatic sym_match_mask_t ent(bit v, int off, logic [63:0] m,
                                          logic [7:0] msk, logic [7:0] b);
    sym_match_mask_t e;
    e.valid = v; e.off = off[7:0]; e.match = m; e.mask = msk; e.buffer = b;
    return e;
  endfunction

  task automatic cyc(bit v, in_t x, bit ordy, bit cv, int ci, sym_match_mask_t ce,
                     output bit acc);
    @(negedge clk);
    chk("drop_cnt", drop_cnt, m_drop);
    in_vld = v; in_w = x; out_rdy = ordy; cfg_vld = cv; cfg_idx = ci[1:0]; cfg_e = ce;
    #1;
    acc = v && in_rdy;
    if (acc) model_word(x);
    if (cv && ci < N) sh[ci] = ce;
  endtask

  task automatic send(in_t x, bit cv = 0, int ci = 0, sym_match_mask_t ce = '0);
    bit a; int t = 0;
    do begin cyc(1, x, 1, cv, ci, ce, a); cv = 0; t++; end while (!a && t < 20);
    if (!a) begin n_chk++; n_fail++; $display("FAIL send_timeout: word not accepted in 20 cycles"); end
  endtask

  task automatic cfgw(int ci, sym_match_mask_t ce);
    bit a;
    cyc(0, '0, 1, 1, ci, ce, a);
  endtask

  task automatic drain();
    bit a; int t = 0;
    while (expq.size() > 0 && t < 50) begin cyc(0, '0, 1, 0, 0, '0, a); t++; end
    cyc(0, '0, 1, 0, 0, '0, a);
    chk("drain_empty", expq.size(), 0);
  endtask

  // monitor: compares every transfer and checks hold stability under backpressure
  initial begin
    out_t held;
    bit   hold;
    hold = 0; held = '0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin hold = 0; continue; end
      chk("in_rdy", in_rdy, !out_vld || out_rdy);
      if (hold) chk("out_stable", out_raw, held);
      if (out_vld && out_rdy) begin
        if (expq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: got %0h expected no word", out_raw);
        end else chk("out_word", out_raw, expq.pop_front());
      end
      hold = out_vld && !out_rdy;
      held = out_raw;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    logic [63:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out", out_raw, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 0;

    // single entry at offset 1
    cfgw(0, ent(1, 1, 64'h1122334455667788, 8'hFF, 8'hA5));
    send(mk(1, 0, 7, 64'h0102030405060708));
    send(mk(0, 0, 7, 64'h1122334455667788));
    send(mk(0, 1, 7, 64'h0000_0000_dead_beef));

    // two hits on word 0: lowest index wins
    cfgw(0, '0);
    cfgw(1, ent(1, 0, '0, 8'h00, 8'h11));
    cfgw(3, ent(1, 0, '0, 8'h00, 8'h33));
    send(mk(1, 0, 7, 64'h5));
    send(mk(0, 1, 2, 64'h6));

    // masked bytes beyond eop length never match
    cfgw(1, '0);
    cfgw(3, '0);
    cfgw(2, ent(1, 0, 64'h0000_AABB_0000_0000, 8'h30, 8'h77));
    send(mk(1, 1, 3, 64'h0000_AABB_0000_0000));
    send(mk(1, 1, 5, 64'h0000_AABB_0000_0000));

    // write on the sop cycle is deferred to the next packet
    cfgw(2, '0);
    cfgw(0, ent(1, 0, '0, 8'h00, 8'h44));
    send(mk(1, 0, 7, 64'h1), 1, 0, ent(1, 0, '0, 8'h00, 8'h55));
    send(mk(0, 1, 7, 64'h2));
    send(mk(1, 1, 7, 64'h3));

    // framing errors
    send(mk(0, 0, 7, 64'h9));
    send(mk(1, 0, 7, 64'hA));
    send(mk(1, 1, 7, 64'hB));
    cyc(0, '0, 1, 0, 0, '0, a);
    chk("drop_after_framing", drop_cnt, 2);

    // backpressure hold
    send(mk(1, 0, 7, 64'hC0));
    for (int i = 0; i < 5; i++) begin
      cyc(1, mk(0, 0, 7, 64'hC1), 0, 0, 0, '0, a);
      chk("stall_accept", a, 0);
    end
    send(mk(0, 1, 7, 64'hC1));

    // word counter saturation
    cfgw(0, ent(1, 255, '0, 8'h00, 8'h99));
    for (int i = 0; i < 258; i++) send(mk(i == 0, i == 257, 7, 64'(i)));
    drain();

    // random traffic
    for (int n = 0; n < 700; n++) begin
      sym_match_mask_t e;
      d = '0;
      for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'($urandom_range(0, 1));
      e = ent($urandom_range(0, 3) != 0, $urandom_range(0, 3), '0,
              8'($urandom), 8'($urandom_range(1, 255)));
      for (int b = 0; b < 8; b++) e.match[8*b +: 8] = 8'($urandom_range(0, 1));
      cyc($urandom_range(0, 3) != 0,
          mk($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7), d),
          $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3), e, a);
    end
    drain();

    // reset mid-packet discards the in-flight word
    send(mk(1, 0, 7, 64'hEE));
    @(negedge clk);
    rst = 1; in_vld = 0; cfg_vld = 0;
    model_reset();
    @(negedge clk);
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    rst = 0;
    send(mk(0, 1, 7, 64'hEF));
    send(mk(1, 1, 7, 64'hF0));
    drain();
    chk("final_drop_cnt", drop_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/m_match_engine.md
# m_match_engine

Streaming packet classifier. It compares each 8-byte input word against N programmable match entries, each keyed by word offset and byte mask, and forwards the word unchanged with a sticky buffer token naming the winning entry. It sits between packet ingress (in_t stream) and the host-facing out_t stream. It is the parametrised successor of the single-entry symbol match: N entries, per-byte masks, shadowed reconfiguration and framing-error handling.

## Interface
- N_MATCH, 4: number of match entries, 1..16.
- DEFAULT_BUFFER, 8'h00: buffer token emitted when no entry has matched.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_vld  in  1  input word valid.
- in  in  $bits(in_t)  input word {sop, eop, length, data}.
- in_rdy  out  1  input accepted when in_vld && in_rdy.
- out_vld  out  1  output word valid.
- out  out  $bits(out_t)  output word {sop, eop, length, data, buffer}.
- out_rdy  in  1  downstream accepts when out_vld && out_rdy.
- cfg_vld  in  1  table write strobe; always accepted.
- cfg_idx  in  $clog2(N_MATCH)  entry index; writes with index ≥ N_MATCH are ignored.
- cfg_entry  in  $bits(sym_match_mask_t)  {valid, off, match, mask, buffer}.
- drop_cnt  out  16  count of words dropped for framing errors; saturates at 16'hFFFF.

## Operation
- State machine has two states:
  - IDLE: an accepted word with sop=1 enters IN_PKT. If that word also has eop=1, it returns to IDLE. An accepted word without sop is dropped: drop_cnt increments and nothing is output.
  - IN_PKT: an accepted word with eop=1 goes to IDLE. An accepted word with sop=1 closes the current packet implicitly: that word is treated as a new packet's first word and drop_cnt increments by one. The prior packet gets no eop.
- Word counter wcnt is 8 bits. It is 0 on the sop word and increments per accepted word, saturating at 8'hFF. Entries with off=8'hFF therefore match every word from word 255 onward.
- Entry i hits on the current word when all of the following hold:
  - active[i].valid is 1.
  - active[i].off == wcnt.
  - For every byte b with mask[b]=1: data[b] == match[b] and byte b is a valid byte. Byte b is valid on non-eop words for all b. On the eop word it is valid only where len_to_unary_mask(length) has bit b set; length is the byte count minus 1.
- An all-zero mask hits on offset alone.
- Sticky verdict per packet:
  - Cleared at sop.
  - The first hit latches the buffer token of the lowest-index hitting entry.
  - Later hits are ignored.
- out.buffer equals the verdict including the current word's hit, or DEFAULT_BUFFER if there has been no hit yet. The buffer on the eop word is the final classification.
- Configuration:
  - cfg writes update a shadow table.
  - The active table is copied from shadow when a sop word is accepted, using shadow contents before any same-cycle write.
  - A write in the same cycle as a sop is therefore seen from the next packet.
- sop, eop, length and data pass through unmodified.

## Timing
- Single output register. Latency is 1 cycle from input acceptance to out_vld.
- in_rdy = !out_vld || out_rdy. This gives full throughput of 1 word/cycle and no combinational path from in_vld to out_vld.
- out holds stable while out_vld && !out_rdy.
- Dropped words are accepted (in_rdy honoured) but produce no output.
- Reset values:
  - out_vld=0, out=0, drop_cnt=0, state=IDLE, wcnt=0, verdict cleared.
  - Shadow and active tables have all valid bits 0.
- Asserting rst mid-packet discards the in-flight output word and any partial verdict.
- The first post-reset word must carry sop; otherwise it is dropped.

## Structure
- Additions to m_pkg:
  - byte_mask_t (logic [7:0]).
  - sym_match_mask_t: sym_match_t fields plus mask.
  - match_state_t enum {IDLE, IN_PKT}.
  - WCNT_MAX constant 8'hFF.
- Sub-module m_match_cmp: combinational, one instance per entry. Inputs are entry, wcnt, data, eop and length; output is hit.
- Top level holds the FSM, wcnt, shadow/active tables, priority select, verdict register, output register and drop counter.

## Test plan
- Entry0 {off=1, match=64'h1122334455667788, mask=8'hFF, buffer=8'hA5}; 3-word packet with word1 matching -> out buffers 00, A5, A5.
- Entries 1 and 3 both hit on word 0 (buffers 8'h11, 8'h33) -> buffer 8'h11 on all words.
- eop word with length=3 and entry mask=8'h30 matching the data bytes -> no hit; buffer stays DEFAULT_BUFFER.
- cfg write to entry0 in the same cycle as a sop -> current packet uses the old entry; the next packet uses the new entry.
- Word without sop in IDLE, then sop mid-packet -> drop_cnt=1, then 2; the mid-packet sop word is output with a fresh verdict.
- out_rdy held low for 5 cycles with in_vld high -> in_rdy=0 and out stable; on release, no word is lost or duplicated.
